decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Pipelined instruction-decode stage between instruction fetch and the operand/constant path.
- Accepts 32-bit instruction words over a valid/ready handshake and splits them into register addresses and the 15-bit immediate.
- Generates the MB (immediate select) and CS (sign-extend vs zero-fill) controls that drive the constant unit.
- Contains a 2-entry elastic buffer (output register plus skid register), so it sustains one instruction per cycle with a fully registered IN_READY.

Parameters:
- ILLEGAL_OP, 7'h7F: opcode flagged as illegal.
- RESET_READY, 1: value of IN_READY after reset (0 holds fetch off until the first post-reset cycle).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  reset, synchronous, active-low.
- IN_INSTR  in  32  instruction word from fetch.
- IN_VALID  in  1  IN_INSTR valid.
- IN_READY  out  1  stage can accept; registered.
- FLUSH  in  1  discard all buffered instructions.
- OUT_VALID  out  1  decoded fields valid.
- OUT_READY  in  1  downstream accepts.
- OPCODE  out  7  IN_INSTR[31:25].
- DA  out  5  IN_INSTR[24:20].
- AA  out  5  IN_INSTR[19:15].
- BA  out  5  IN_INSTR[14:10].
- IM  out  15  IN_INSTR[14:0], to constant unit.
- MB  out  1  OPCODE[6]: 1 selects the constant as operand B.
- CS  out  1  OPCODE[6] & OPCODE[5]: 1 = sign-extend IM, 0 = zero-fill. Forced to 0 when MB=0.
- ILLEGAL  out  1  OPCODE == ILLEGAL_OP.

Behaviour:
- Clock and reset: single clock CLK; reset RST_N is synchronous, active-low, sampled only on rising CLK.
- Reset values (held while RST_N=0): OUT_VALID=0, all field outputs=0, ILLEGAL=0, skid empty. IN_READY=RESET_READY on the first cycle after release, 1 from then on.
- Decode is combinational on IN_INSTR. Result is stored with its instruction as one record {OPCODE, DA, AA, BA, IM, MB, CS, ILLEGAL}.
- Accept occurs when IN_VALID & IN_READY. Output transfer occurs when OUT_VALID & OUT_READY.
- Latency: accepted word appears on outputs with OUT_VALID=1 the next cycle, i.e. 1 cycle.
- Buffer states:
  - EMPTY (OUT_VALID=0, skid empty).
  - ONE (OUT_VALID=1, skid empty).
  - FULL (OUT_VALID=1, skid holds one record).
- Transitions:
  - EMPTY: accept -> ONE, record loads into the output register.
  - ONE, accept & transfer: -> ONE, output register reloads with the new record.
  - ONE, accept & no transfer: -> FULL, new record goes to skid.
  - ONE, transfer & no accept: -> EMPTY.
  - FULL, transfer: -> ONE, skid moves to the output register. No accept is possible in FULL.
- IN_READY is registered: IN_READY(next) = 1 unless next state is FULL.
- Order is strictly FIFO. No record is dropped or duplicated.
- Outputs hold stable while OUT_VALID=1 & OUT_READY=0.
- FLUSH=1: next state EMPTY, IN_READY=1 next cycle.
  - Any accept or transfer in the same cycle has no effect on buffer contents.
  - The upstream word offered that cycle is consumed and dropped if IN_READY was 1.
- Reset has priority over FLUSH. Reset mid-stall discards all buffered records.
- ILLEGAL instructions pass through normally with ILLEGAL=1. Downstream handles them.
- No arithmetic is performed. IM is passed unmodified; extension is done downstream.

Optional Feature:
- Macro: DECODE_STALL_CNT_EN.
- Defined:
  - Adds output STALL_CNT [15:0].
  - Increments by 1 every cycle with OUT_VALID=1 & OUT_READY=0.
  - Saturates at 16'hFFFF, clears on reset, unaffected by FLUSH.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Sign-extend immediate: reset 2 cycles; IN_INSTR=32'hC0324000, IN_VALID=1, OUT_READY=1 -> next cycle OUT_VALID=1, OPCODE=7'h60, DA=3, AA=4, IM=15'h4000, MB=1, CS=1, ILLEGAL=0.
2. Zero-fill and register form: IN_INSTR=32'h80324000 -> MB=1, CS=0, IM=15'h4000. Then IN_INSTR=32'h04110C00 -> MB=0, CS=0, DA=1, AA=2, BA=3.
3. Backpressure: stream 3 words A,B,C with OUT_READY=0 -> A held on outputs, B in skid, IN_READY=0 from the cycle after B is accepted. Raise OUT_READY -> A, B, C emerge in order with no loss.
4. Throughput: 8 consecutive words with IN_VALID=1 and OUT_READY=1 -> IN_READY stays 1 and OUT_VALID is 1 for 8 consecutive cycles.
5. Flush in FULL, then reset: from FULL assert FLUSH 1 cycle -> next cycle OUT_VALID=0, IN_READY=1, and stale words never appear. Then RST_N=0 mid-stream -> all outputs 0 on the next edge.
6. ILLEGAL and STALL_CNT: IN_INSTR=32'hFE000000 -> ILLEGAL=1, OUT_VALID=1. With DECODE_STALL_CNT_EN defined, hold OUT_READY=0 for 5 cycles with OUT_VALID=1 -> STALL_CNT=5.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: instruction field/MB/CS decode with 2-entry elastic buffer; DECODE_STALL_CNT_EN adds STALL_CNT
module decode_stage #(
  parameter logic [6:0] ILLEGAL_OP  = 7'h7F,
  parameter bit         RESET_READY = 1'b1
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] IN_INSTR,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        FLUSH,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [6:0]  OPCODE,
  output logic [4:0]  DA,
  output logic [4:0]  AA,
  output logic [4:0]  BA,
  output logic [14:0] IM,
  output logic        MB,
  output logic        CS,
`ifdef DECODE_STALL_CNT_EN
  output logic [15:0] STALL_CNT,
`endif
  output logic        ILLEGAL
);
  logic [39:0] dec, out_q, out_d, skid_q, skid_d;
  logic out_v_q, out_v_d, skid_v_q, skid_v_d, rdy_q, acc, xfer;
  // record layout: {OPCODE, DA, AA, BA, IM, MB, CS, ILLEGAL}
  assign dec = {IN_INSTR[31:10], IN_INSTR[14:0], IN_INSTR[31], IN_INSTR[31] & IN_INSTR[30],
                IN_INSTR[31:25] == ILLEGAL_OP};
  assign acc = IN_VALID & rdy_q;
  assign xfer = out_v_q & OUT_READY;
  always_comb begin
    out_d = (skid_v_q & xfer) ? skid_q : (acc & (!out_v_q | xfer)) ? dec : out_q;
    skid_d = (acc & out_v_q & !xfer) ? dec : skid_q;
    skid_v_d = !FLUSH & (skid_v_q ? !xfer : acc & out_v_q & !xfer);
    out_v_d = !FLUSH & (skid_v_q | acc | (out_v_q & !OUT_READY));
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      out_q <= '0;
      skid_q <= '0;
      out_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      rdy_q <= RESET_READY;
    end else begin
      out_q <= out_d;
      skid_q <= skid_d;
      out_v_q <= out_v_d;
      skid_v_q <= skid_v_d;
      rdy_q <= !skid_v_d;
    end
  end
  assign IN_READY = rdy_q;
  assign OUT_VALID = out_v_q;
  assign {OPCODE, DA, AA, BA, IM, MB, CS, ILLEGAL} = out_q;
`ifdef DECODE_STALL_CNT_EN
  logic [15:0] stall_cnt_q;
  always_ff @(posedge CLK) begin
    if (!RST_N) stall_cnt_q <= '0;
    else if (out_v_q & !OUT_READY & (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
  end
  assign STALL_CNT = stall_cnt_q;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with hand-computed expectations for decode_stage
module tb_decode_stage;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, flush, out_valid, out_ready, mb, cs, illegal;
  logic [31:0] in_instr;
  logic [6:0] opcode;
  logic [4:0] da, aa, ba;
  logic [14:0] im;
`ifdef DECODE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  decode_stage dut (
    .CLK(clk), .RST_N(rst_n), .IN_INSTR(in_instr), .IN_VALID(in_valid), .IN_READY(in_ready),
    .FLUSH(flush), .OUT_VALID(out_valid), .OUT_READY(out_ready), .OPCODE(opcode), .DA(da),
    .AA(aa), .BA(ba), .IM(im), .MB(mb), .CS(cs),
`ifdef DECODE_STALL_CNT_EN
    .STALL_CNT(stall_cnt),
`endif
    .ILLEGAL(illegal)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; out_ready = 1'b1;
    tick; tick;
    chk("rst_ovalid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_da", da, 0);
    chk("rst_ill", illegal, 0);
    rst_n = 1'b1;
    // sign-extend form
    in_instr = 32'hC0324000; in_valid = 1'b1; tick;
    chk("t1_ovalid", out_valid, 1);
    chk("t1_op", opcode, 7'h60);
    chk("t1_da", da, 3);
    chk("t1_aa", aa, 4);
    chk("t1_ba", ba, 16);
    chk("t1_im", im, 15'h4000);
    chk("t1_mb", mb, 1);
    chk("t1_cs", cs, 1);
    chk("t1_ill", illegal, 0);
    // zero-fill and register form
    in_instr = 32'h80324000; tick;
    chk("t2a_op", opcode, 7'h40);
    chk("t2a_mb", mb, 1);
    chk("t2a_cs", cs, 0);
    chk("t2a_im", im, 15'h4000);
    in_instr = 32'h04110C00; tick;
    chk("t2b_mb", mb, 0);
    chk("t2b_cs", cs, 0);
    chk("t2b_da", da, 1);
    chk("t2b_aa", aa, 2);
    chk("t2b_ba", ba, 3);
    chk("t2b_im", im, 15'h0C00);
    in_valid = 1'b0; tick;
    chk("t2_drain", out_valid, 0);
    // backpressure: A, B, C
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00A00000; tick;
    chk("t3_a_da", da, 10);
    chk("t3_a_rdy", in_ready, 1);
    in_instr = 32'h00B00000; tick;
    chk("t3_full_da", da, 10);
    chk("t3_full_rdy", in_ready, 0);
    in_instr = 32'h00C00000; tick;
    chk("t3_hold_da", da, 10);
    chk("t3_hold_ov", out_valid, 1);
    chk("t3_hold_rdy", in_ready, 0);
    out_ready = 1'b1; tick;
    chk("t3_b_da", da, 11);
    chk("t3_b_rdy", in_ready, 1);
    tick;
    chk("t3_c_da", da, 12);
    in_valid = 1'b0; tick;
    chk("t3_empty", out_valid, 0);
    // throughput
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_instr = 32'(i + 1) << 20;
      tick;
      chk("t4_ov", out_valid, 1);
      chk("t4_rdy", in_ready, 1);
      chk("t4_da", da, i + 1);
    end
    in_valid = 1'b0; tick;
    chk("t4_end", out_valid, 0);
    // flush from FULL
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h01E00000; tick;
    in_instr = 32'h01F00000; tick;
    chk("t5_full_rdy", in_ready, 0);
    in_valid = 1'b0; flush = 1'b1; tick;
    flush = 1'b0;
    chk("t5_fl_ov", out_valid, 0);
    chk("t5_fl_rdy", in_ready, 1);
    out_ready = 1'b1; tick;
    chk("t5_no_stale", out_valid, 0);
    tick;
    chk("t5_no_stale2", out_valid, 0);
    // reset mid-stream
    in_valid = 1'b1; in_instr = 32'hC0324000; tick;
    chk("t5_pre_da", da, 3);
    rst_n = 1'b0; tick;
    chk("t5_rst_ov", out_valid, 0);
    chk("t5_rst_op", opcode, 0);
    chk("t5_rst_da", da, 0);
    chk("t5_rst_im", im, 0);
    chk("t5_rst_mb", mb, 0);
    rst_n = 1'b1; in_valid = 1'b0; tick;
    chk("t5_post_ov", out_valid, 0);
    // illegal opcode and stall accounting
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFE000000; tick;
    in_valid = 1'b0;
    chk("t6_ov", out_valid, 1);
    chk("t6_ill", illegal, 1);
    chk("t6_op", opcode, 7'h7F);
    for (int i = 0; i < 5; i++) tick;
    chk("t6_hold_ov", out_valid, 1);
    chk("t6_hold_ill", illegal, 1);
`ifdef DECODE_STALL_CNT_EN
    chk("t6_stall", stall_cnt, 5);
`endif
    out_ready = 1'b1; tick;
    chk("t6_drain", out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
